// File: rtl/regbank_pkg.sv
// Shared defaults and types for the clocked register bank and its busy scoreboard.
package regbank_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regbank_scoreboard.sv
// Per-register busy scoreboard: reservation accept, release on writeback, flush, registered busy count.
// Optional REGBANK_R0_ZERO_EN: reservations of register 0 are acked but never mark it busy.
module regbank_scoreboard
    import regbank_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rsv_ack,
    output logic              busy_a,
    output logic              busy_b,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int N = 2 ** ADDR_W;

    logic [N-1:0]    busy_q;
    logic [N-1:0]    busy_d;
    logic [ADDR_W:0] cnt_d;
    logic            set_ok;

`ifdef REGBANK_R0_ZERO_EN
    assign set_ok = (rsv_addr != '0);
`else
    assign set_ok = 1'b1;
`endif

    // A writeback landing this cycle frees the register, so it may be re-reserved at once.
    assign rsv_ack = !rst && rsv_en && !flush &&
                     (!busy_q[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));

    assign busy_a = busy_q[rd_addr_a] && !(wr_en && (wr_addr == rd_addr_a));
    assign busy_b = busy_q[rd_addr_b] && !(wr_en && (wr_addr == rd_addr_b));

    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_ack && set_ok) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        cnt_d = '0;
        for (int i = 0; i < N; i++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= '0;
            busy_cnt <= '0;
        end else begin
            busy_q   <= busy_d;
            busy_cnt <= cnt_d;
        end
    end

endmodule

// File: rtl/register_bank_sb.sv
// Register bank: two async read ports with write-through forwarding, one sync write port, busy scoreboard.
// Optional REGBANK_R0_ZERO_EN hardwires register 0 to zero (writes and forwarding from address 0 dropped).
module register_bank_sb
    import regbank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic [DATA_W-1:0] PRA,
    output logic [DATA_W-1:0] PRB,
    output logic              RA_BUSY,
    output logic              RB_BUSY,
    input  logic [ADDR_W-1:0] WC,
    input  logic [DATA_W-1:0] WPC,
    input  logic              W_RB,
    input  logic              RSV_EN,
    input  logic [ADDR_W-1:0] RSV_ADDR,
    output logic              RSV_ACK,
    input  logic              FLUSH,
    output logic [ADDR_W:0]   BUSY_CNT
);

    localparam int N = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [N];
    logic              wr_eff;
    logic              fwd_a;
    logic              fwd_b;
    logic              busy_a;
    logic              busy_b;

`ifdef REGBANK_R0_ZERO_EN
    assign wr_eff = W_RB && (WC != '0);
`else
    assign wr_eff = W_RB;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_eff) begin
            mem[WC] <= WPC;
        end
    end

    assign fwd_a = wr_eff && (WC == RA);
    assign fwd_b = wr_eff && (WC == RB);

    // Forwarded write data is gated too, so reset drives all read data to zero.
    assign PRA = RESET ? '0 : (fwd_a ? WPC : mem[RA]);
    assign PRB = RESET ? '0 : (fwd_b ? WPC : mem[RB]);

    regbank_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (CLK),
        .rst       (RESET),
        .wr_en     (wr_eff),
        .wr_addr   (WC),
        .rsv_en    (RSV_EN),
        .rsv_addr  (RSV_ADDR),
        .flush     (FLUSH),
        .rd_addr_a (RA),
        .rd_addr_b (RB),
        .rsv_ack   (RSV_ACK),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .busy_cnt  (BUSY_CNT)
    );

    assign RA_BUSY = busy_a;
    assign RB_BUSY = busy_b;

endmodule

// File: tb/tb_register_bank_sb.sv
// Bench for register_bank_sb: directed table, hand-written corner sequences and random traffic vs a reference model.
module tb_register_bank_sb;
    import regbank_pkg::*;

    localparam int AW = ADDR_W_DEF;
    localparam int N  = DEPTH;
`ifdef REGBANK_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    reg_addr_t   RA, RB, WC, RSV_ADDR;
    reg_data_t   PRA, PRB, WPC;
    logic        RA_BUSY, RB_BUSY, W_RB, RSV_EN, RSV_ACK, FLUSH;
    logic [AW:0] BUSY_CNT;

    register_bank_sb dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .RA       (RA),
        .RB       (RB),
        .PRA      (PRA),
        .PRB      (PRB),
        .RA_BUSY  (RA_BUSY),
        .RB_BUSY  (RB_BUSY),
        .WC       (WC),
        .WPC      (WPC),
        .W_RB     (W_RB),
        .RSV_EN   (RSV_EN),
        .RSV_ADDR (RSV_ADDR),
        .RSV_ACK  (RSV_ACK),
        .FLUSH    (FLUSH),
        .BUSY_CNT (BUSY_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference state: architectural register contents and the set of busy registers.
    reg_data_t m_mem  [N];
    bit        m_busy [N];

    typedef struct {
        bit          rsv_en;
        int          rsv_addr;
        bit          w;
        int          wc;
        logic [31:0] wpc;
        bit          flush;
        int          ra;
        bit          e_ack;
        bit          e_ra_busy;
        int          e_cnt_after;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit wr_hits(input reg_addr_t a);
        return W_RB && !(R0Z && WC == '0) && (WC == a);
    endfunction

    function automatic reg_data_t m_read(input reg_addr_t a);
        if (RESET) return '0;
        if (R0Z && a == '0) return '0;
        if (wr_hits(a)) return WPC;
        return m_mem[a];
    endfunction

    function automatic bit m_busy_flag(input reg_addr_t a);
        return !RESET && m_busy[a] && !wr_hits(a);
    endfunction

    function automatic bit m_ack();
        return !RESET && RSV_EN && !FLUSH && (!m_busy[RSV_ADDR] || wr_hits(RSV_ADDR));
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        W_RB = 1'b0; RSV_EN = 1'b0; FLUSH = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".pra"},  64'(PRA),      64'(m_read(RA)));
        chk({tag, ".prb"},  64'(PRB),      64'(m_read(RB)));
        chk({tag, ".rab"},  64'(RA_BUSY),  64'(m_busy_flag(RA)));
        chk({tag, ".rbb"},  64'(RB_BUSY),  64'(m_busy_flag(RB)));
        chk({tag, ".ack"},  64'(RSV_ACK),  64'(m_ack()));
        chk({tag, ".cnt"},  64'(BUSY_CNT), 64'(m_cnt()));
    endtask

    // Advance one clock; the model commits the same inputs the DUT sees at the edge.
    task automatic tick();
        bit ack;
        ack = m_ack();
        @(posedge CLK);
        if (W_RB && !(R0Z && WC == '0)) begin
            m_mem[WC]  = WPC;
            m_busy[WC] = 1'b0;
        end
        if (FLUSH) begin
            for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
        end else if (ack && !(R0Z && RSV_ADDR == '0)) begin
            m_busy[RSV_ADDR] = 1'b1;
        end
        #1;
    endtask

    task automatic step(input string tag);
        #1;
        check_outputs(tag);
        tick();
    endtask

    initial begin
        RESET = 1'b1;
        RA = '0; RB = '0; WC = '0; RSV_ADDR = '0; WPC = '0;
        idle();
        model_reset();

        tbl[0] = '{1, 3, 0, 0, 32'h0,        0, 3, 1, 0, 1};
        tbl[1] = '{1, 3, 0, 0, 32'h0,        0, 3, 0, 1, 1};
        tbl[2] = '{0, 0, 1, 3, 32'hA5A5_0303, 0, 3, 0, 0, 0};
        tbl[3] = '{1, 7, 0, 0, 32'h0,        0, 7, 1, 0, 1};
        tbl[4] = '{1, 7, 1, 7, 32'h7777_0007, 0, 7, 1, 0, 1};
        tbl[5] = '{0, 0, 0, 0, 32'h0,        0, 7, 0, 1, 1};
        tbl[6] = '{1, 9, 0, 0, 32'h0,        1, 7, 0, 1, 0};
        tbl[7] = '{0, 0, 0, 0, 32'h0,        0, 7, 0, 0, 0};

        // Reset: outputs zero even with a forwarding write and reservation driven.
        W_RB = 1'b1; WC = 4'd2; RA = 4'd2; RB = 4'd2; WPC = 32'h1234_5678;
        RSV_EN = 1'b1; RSV_ADDR = 4'd2;
        #2;
        chk("rst.pra", 64'(PRA), 64'd0);
        chk("rst.prb", 64'(PRB), 64'd0);
        chk("rst.rab", 64'(RA_BUSY), 64'd0);
        chk("rst.ack", 64'(RSV_ACK), 64'd0);
        chk("rst.cnt", 64'(BUSY_CNT), 64'd0);
        @(posedge CLK);
        #1;
        idle();
        RESET = 1'b0;

        // Random fill of every register, then pairwise read-back.
        for (int i = 0; i < N; i++) begin
            W_RB = 1'b1; WC = reg_addr_t'(i); WPC = $urandom;
            RA = reg_addr_t'(i); RB = reg_addr_t'(i + 1);
            step("fill");
        end
        idle();
        for (int i = 0; i < N; i++) begin
            RA = reg_addr_t'(i); RB = reg_addr_t'(i + 1);
            step("readback");
        end

        // Forwarding on register 5.
        W_RB = 1'b1; WC = 4'd5; WPC = 32'h1111_1111; RA = 4'd5; RB = 4'd4;
        step("fwd.seed");
        WPC = 32'hDEAD_BEEF;
        #1;
        chk("fwd.before", 64'(PRA), 64'hDEAD_BEEF);
        tick();
        idle();
        #1;
        chk("fwd.after", 64'(PRA), 64'hDEAD_BEEF);

        // Directed reservation / release / flush table.
        for (int i = 0; i < 8; i++) begin
            RSV_EN = tbl[i].rsv_en; RSV_ADDR = reg_addr_t'(tbl[i].rsv_addr);
            W_RB = tbl[i].w; WC = reg_addr_t'(tbl[i].wc); WPC = tbl[i].wpc;
            FLUSH = tbl[i].flush;
            RA = reg_addr_t'(tbl[i].ra); RB = reg_addr_t'(tbl[i].ra + 1);
            #1;
            chk($sformatf("tbl%0d.ack", i), 64'(RSV_ACK), 64'(tbl[i].e_ack));
            chk($sformatf("tbl%0d.rab", i), 64'(RA_BUSY), 64'(tbl[i].e_ra_busy));
            check_outputs($sformatf("tbl%0d", i));
            tick();
            chk($sformatf("tbl%0d.cnt", i), 64'(BUSY_CNT), 64'(tbl[i].e_cnt_after));
        end
        idle();
        RA = 4'd7;
        #1;
        chk("tbl.r7data", 64'(PRA), 64'h7777_0007);

        // Reserve everything, then flush against a competing reservation.
        for (int i = 0; i < N; i++) begin
            RSV_EN = 1'b1; RSV_ADDR = reg_addr_t'(i); RA = reg_addr_t'(i);
            step("full");
        end
        chk("full.cnt", 64'(BUSY_CNT), R0Z ? 64'd15 : 64'd16);
        FLUSH = 1'b1; RSV_EN = 1'b1; RSV_ADDR = 4'd4;
        #1;
        chk("flush.ack", 64'(RSV_ACK), 64'd0);
        tick();
        chk("flush.cnt", 64'(BUSY_CNT), 64'd0);
        idle();

        // Reset in the middle of traffic.
        RSV_EN = 1'b1; RSV_ADDR = 4'd2; step("mid.r2");
        RSV_ADDR = 4'd5; step("mid.r5");
        W_RB = 1'b1; WC = 4'd5; WPC = 32'hCAFE_F00D; RA = 4'd5; RB = 4'd2; RSV_ADDR = 4'd9;
        RESET = 1'b1;
        #1;
        chk("mid.pra", 64'(PRA), 64'd0);
        chk("mid.prb", 64'(PRB), 64'd0);
        chk("mid.rbb", 64'(RB_BUSY), 64'd0);
        chk("mid.ack", 64'(RSV_ACK), 64'd0);
        chk("mid.cnt", 64'(BUSY_CNT), 64'd0);
        model_reset();
        @(posedge CLK);
        #1;
        idle();
        RESET = 1'b0;
        RA = 4'd2; RB = 4'd5;
        step("post.rst");

`ifdef REGBANK_R0_ZERO_EN
        W_RB = 1'b1; WC = 4'd0; WPC = 32'hFFFF_FFFF; RA = 4'd0;
        #1;
        chk("r0.fwd", 64'(PRA), 64'd0);
        tick();
        idle();
        #1;
        chk("r0.read", 64'(PRA), 64'd0);
        RSV_EN = 1'b1; RSV_ADDR = 4'd0;
        #1;
        chk("r0.ack", 64'(RSV_ACK), 64'd1);
        tick();
        idle();
        #1;
        chk("r0.busy", 64'(RA_BUSY), 64'd0);
        chk("r0.cnt", 64'(BUSY_CNT), 64'd0);
`else
        W_RB = 1'b1; WC = 4'd0; WPC = 32'hFFFF_FFFF; RA = 4'd0;
        tick();
        idle();
        #1;
        chk("r0.read", 64'(PRA), 64'hFFFF_FFFF);
        RSV_EN = 1'b1; RSV_ADDR = 4'd0;
        tick();
        idle();
        #1;
        chk("r0.busy", 64'(RA_BUSY), 64'd1);
        chk("r0.cnt", 64'(BUSY_CNT), 64'd1);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            RA = reg_addr_t'($urandom_range(N - 1));
            RB = reg_addr_t'($urandom_range(N - 1));
            WC = reg_addr_t'($urandom_range(N - 1));
            RSV_ADDR = reg_addr_t'($urandom_range(N - 1));
            WPC = $urandom;
            W_RB = ($urandom_range(2) == 0);
            RSV_EN = ($urandom_range(1) == 1);
            FLUSH = ($urandom_range(15) == 0);
            step("rnd");
        end
        idle();
        #1;
        check_outputs("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/register_bank_sb.md
Name: register_bank_sb

Overview:
Parametrised, clocked successor to the register bank, for the pipelined core.
- Storage: 2**ADDR_W registers of DATA_W bits.
- Reads: two asynchronous read ports, with write-through forwarding.
- Writes: one synchronous write port.
- Hazard tracking: a per-register busy scoreboard. Issue logic reserves a destination register; writeback releases it.
- Position: between decode/issue (reads, reservations) and writeback (writes).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 4, register address width; depth = 2**ADDR_W

Ports:
CLK  in  1  clock; all state updates on the rising edge
RESET  in  1  asynchronous, active-high reset
RA  in  ADDR_W  read address, port A
RB  in  ADDR_W  read address, port B
PRA  out  DATA_W  read data, port A
PRB  out  DATA_W  read data, port B
RA_BUSY  out  1  register RA has a pending write
RB_BUSY  out  1  register RB has a pending write
WC  in  ADDR_W  write address
WPC  in  DATA_W  write data
W_RB  in  1  write enable
RSV_EN  in  1  reservation request
RSV_ADDR  in  ADDR_W  register to reserve
RSV_ACK  out  1  reservation accepted this cycle
FLUSH  in  1  clear all reservations
BUSY_CNT  out  ADDR_W+1  number of busy registers

Behaviour:
- Reset (asynchronous, active-high): all registers, busy bits and BUSY_CNT go to 0. While RESET is high:
  - PRA = PRB = 0; RA_BUSY = RB_BUSY = 0.
  - RSV_ACK = 0; writes and reservations are ignored.
- Reset mid-operation: all in-flight reservations are lost; nothing else is retained.
- Write: on rising CLK with W_RB=1, reg[WC] <= WPC and busy[WC] <= 0.
- Read (combinational, zero latency):
  - PRA = WPC when W_RB && WC==RA; otherwise PRA = reg[RA]. PRB likewise with RB.
  - Two ports reading the same address see the same value.
- Busy flags:
  - RA_BUSY = busy[RA] && !(W_RB && WC==RA); RB_BUSY likewise. A same-cycle write resolves the hazard.
- Reservation:
  - RSV_ACK = RSV_EN && !FLUSH && (!busy[RSV_ADDR] || (W_RB && WC==RSV_ADDR)).
  - On an acked edge, busy[RSV_ADDR] <= 1.
  - A reservation to an already-busy register that is not being written is refused: RSV_ACK=0 and state is unchanged. The requester retries.
- Write and reserve to the same address in one cycle: the data is stored and busy ends at 1, so the reservation wins.
- FLUSH:
  - On the edge, all busy bits clear. FLUSH beats reservation: RSV_ACK is forced to 0.
  - The write still occurs.
- BUSY_CNT: registered population count of busy bits after each edge. Range 0..2**ADDR_W; the ADDR_W+1 width prevents wrap when all registers are busy.
- Address arithmetic is unsigned; no out-of-range case exists.

Optional Feature:
Macro: REGBANK_R0_ZERO_EN.
- Defined: register 0 is hardwired to zero.
  - Reads of address 0 return 0.
  - Writes to 0 are dropped, and forwarding from WC==0 is suppressed.
  - Reservations of 0 are acked (RSV_ACK=1 when RSV_EN && !FLUSH) but never set busy. RA_BUSY/RB_BUSY for address 0 are always 0.
- Undefined: register 0 behaves like every other register.

Decomposition:
- Package regbank_pkg holds:
  - defaults DATA_W_DEF=32, ADDR_W_DEF=4;
  - derived constant DEPTH=2**ADDR_W;
  - typedefs reg_addr_t and reg_data_t.
- One natural sub-module: regbank_scoreboard. It holds the busy vector, RSV_ACK logic, FLUSH and BUSY_CNT.
- Storage and forwarding stay in the top level.

Test Plan:
- Reset, then random fill: assert RESET, then write 16 random words to addresses 0..15 with W_RB=1. Read pairs (i, i+1) -> PRA/PRB match the written words; all busy flags 0; BUSY_CNT=0.
- Forwarding: reg[5]=0x11111111; drive W_RB=1, WC=5, WPC=0xDEADBEEF, RA=5 in the same cycle -> PRA=0xDEADBEEF before the edge and after it.
- Reservation and release:
  - Reserve 3 -> RSV_ACK=1; next cycle RA=3 gives RA_BUSY=1 and BUSY_CNT=1.
  - Reserve 3 again -> RSV_ACK=0.
  - Write 3 -> RA_BUSY=0 in that cycle; BUSY_CNT=0 after the edge.
- Simultaneous write + reserve: busy[7]=1; W_RB=1, WC=7, RSV_EN=1, RSV_ADDR=7 -> RSV_ACK=1; reg[7] updated; busy[7] remains 1; BUSY_CNT unchanged.
- Full and flush:
  - Reserve all 16 registers -> BUSY_CNT=16 (5'b10000).
  - FLUSH=1 with RSV_EN=1 -> RSV_ACK=0; BUSY_CNT=0 after the edge.
  - RESET pulsed mid-sequence -> all outputs 0 immediately.
- REGBANK_R0_ZERO_EN defined: write 0xFFFFFFFF to address 0 -> PRA(RA=0)=0. Reserve 0 -> RSV_ACK=1, RA_BUSY=0, BUSY_CNT=0.
